// File: rtl/keyboard_tracker.sv
// keyboard_tracker: press-ordered table of held PS/2 keys mapped onto a 16-bit action bus
// with press/release/repeat pulses, held count and overflow.
module keyboard_tracker #(
    parameter int MAX_HELD     = 4,
    parameter int MODE         = 0,
    parameter int REPEAT_DELAY = 50_000_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_keycode,
    input  logic        i_key_valid,
    input  logic        i_clear,
    output logic [15:0] o_keyboard_data,
    output logic [15:0] o_press_pulse,
    output logic [15:0] o_release_pulse,
    output logic [15:0] o_repeat_pulse,
    output logic [3:0]  o_held_count,
    output logic        o_overflow
);
    localparam int CW = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);

    function automatic logic [15:0] f_map(input logic [7:0] code);
        case (code)
            8'h1D:   f_map = 16'h0001;
            8'h1C:   f_map = 16'h0002;
            8'h1B:   f_map = 16'h0004;
            8'h23:   f_map = 16'h0008;
            8'h24:   f_map = 16'h0010;
            8'h5A:   f_map = 16'h0020;
            8'h29:   f_map = 16'h0040;
            8'h6B:   f_map = 16'h0080;
            8'h73:   f_map = 16'h0100;
            8'h74:   f_map = 16'h0200;
            8'h75:   f_map = 16'h0400;
            8'h5B:   f_map = 16'h0800;
            8'h5D:   f_map = 16'h1000;
            8'h15:   f_map = 16'h2000;
            8'h2D:   f_map = 16'h4000;
            8'h76:   f_map = 16'h8000;
            default: f_map = 16'h0000;
        endcase
    endfunction

    logic [7:0]          r_code [MAX_HELD];
    logic [MAX_HELD-1:0] r_valid;
    logic [15:0]         r_press_ev;
    logic [15:0]         r_rel_ev;
    logic                r_ovf_ev;
    logic [CW-1:0]       r_cnt;
    logic                r_rep_phase;

    logic [7:0]          w_code_nxt [MAX_HELD];
    logic [MAX_HELD-1:0] w_valid_nxt;
    logic [MAX_HELD-1:0] w_after;
    logic                w_any_hit;
    logic                w_is_rel;
    logic                w_act;
    logic                w_full;
    logic                w_do_press;
    logic                w_do_rel;
    logic [15:0]         w_press_ev;
    logic [15:0]         w_rel_ev;
    logic [15:0]         w_data;
    logic [3:0]          w_count;
    logic                w_reload;
    logic                w_fire;
    logic [CW-1:0]       w_cnt_inc;
    logic [15:0]         w_rep;

    // w_after marks the matching slot and every older slot, i.e. the entries that move up on release
    always_comb begin
        logic acc;
        acc = 1'b0;
        w_after = '0;
        for (int k = 0; k < MAX_HELD; k++) begin
            acc = acc | (r_valid[k] && r_code[k] == i_keycode[7:0]);
            w_after[k] = acc;
        end
        w_any_hit = acc;
    end

    always_comb begin
        w_is_rel   = i_keycode[15:8] == 8'hF0;
        w_act      = i_key_valid && !i_clear && i_keycode[7:0] != 8'h00;
        w_full     = r_valid[MAX_HELD-1];
        w_do_press = w_act && !w_is_rel && !w_any_hit;
        w_do_rel   = w_act && w_is_rel && w_any_hit;
        w_code_nxt  = r_code;
        w_valid_nxt = r_valid;
        if (i_clear) begin
            w_valid_nxt = '0;
        end else if (w_do_press) begin
            w_code_nxt[0]  = i_keycode[7:0];
            w_valid_nxt[0] = 1'b1;
            for (int k = 1; k < MAX_HELD; k++) begin
                w_code_nxt[k]  = r_code[k-1];
                w_valid_nxt[k] = r_valid[k-1];
            end
        end else if (w_do_rel) begin
            for (int k = 0; k < MAX_HELD - 1; k++) begin
                if (w_after[k]) begin
                    w_code_nxt[k]  = r_code[k+1];
                    w_valid_nxt[k] = r_valid[k+1];
                end
            end
            if (w_after[MAX_HELD-1])
                w_valid_nxt[MAX_HELD-1] = 1'b0;
        end
        w_press_ev = w_do_press ? f_map(i_keycode[7:0]) : 16'h0000;
        w_rel_ev   = w_do_rel ? f_map(i_keycode[7:0]) :
                     (w_do_press && w_full) ? f_map(r_code[MAX_HELD-1]) : 16'h0000;
    end

    always_comb begin
        w_data  = '0;
        w_count = '0;
        for (int k = 0; k < MAX_HELD; k++) begin
            if (r_valid[k] && (MODE != 0 || k == 0))
                w_data = w_data | f_map(r_code[k]);
            if (r_valid[k])
                w_count = w_count + 4'd1;
        end
    end

    // the repeat timer restarts whenever the newest key changes identity or the table empties
    always_comb begin
        w_reload  = !w_valid_nxt[0] || !r_valid[0] || w_code_nxt[0] != r_code[0];
        w_cnt_inc = r_cnt + 1'b1;
        w_fire    = !w_reload && w_cnt_inc == (r_rep_phase ? CW'(REPEAT_RATE) : CW'(REPEAT_DELAY));
        w_rep     = w_fire ? f_map(r_code[0]) : 16'h0000;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_code          <= '{default: '0};
            r_valid         <= '0;
            r_press_ev      <= '0;
            r_rel_ev        <= '0;
            r_ovf_ev        <= 1'b0;
            r_cnt           <= '0;
            r_rep_phase     <= 1'b0;
            o_keyboard_data <= '0;
            o_press_pulse   <= '0;
            o_release_pulse <= '0;
            o_repeat_pulse  <= '0;
            o_held_count    <= '0;
            o_overflow      <= 1'b0;
        end else begin
            r_code          <= w_code_nxt;
            r_valid         <= w_valid_nxt;
            r_press_ev      <= w_press_ev;
            r_rel_ev        <= w_rel_ev;
            r_ovf_ev        <= w_do_press && w_full;
            r_cnt           <= (w_reload || w_fire) ? '0 : w_cnt_inc;
            r_rep_phase     <= !w_reload && (r_rep_phase || w_fire);
            o_keyboard_data <= w_data;
            o_press_pulse   <= r_press_ev;
            o_release_pulse <= r_rel_ev;
            o_repeat_pulse  <= w_rep;
            o_held_count    <= w_count;
            o_overflow      <= r_ovf_ev;
        end
    end
endmodule

// File: tb/tb_keyboard_tracker.sv
// tb_keyboard_tracker: drives MODE 0 and MODE 1 trackers with directed and random key traffic
// and compares every output each cycle against a queue-based model of the held keys.
module tb_keyboard_tracker;
    localparam int MAXH  = 4;
    localparam int DELAY = 10;
    localparam int RATE  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] keycode = '0;
    logic        key_valid = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] data0, press0, rel0, rep0, data1, press1, rel1, rep1;
    logic [3:0]  cnt0, cnt1;
    logic        ovf0, ovf1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    keyboard_tracker #(.MAX_HELD(MAXH), .MODE(0), .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE)) u_m0 (
        .clk(clk), .rst_n(rst_n), .i_keycode(keycode), .i_key_valid(key_valid), .i_clear(clear),
        .o_keyboard_data(data0), .o_press_pulse(press0), .o_release_pulse(rel0),
        .o_repeat_pulse(rep0), .o_held_count(cnt0), .o_overflow(ovf0)
    );

    keyboard_tracker #(.MAX_HELD(MAXH), .MODE(1), .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE)) u_m1 (
        .clk(clk), .rst_n(rst_n), .i_keycode(keycode), .i_key_valid(key_valid), .i_clear(clear),
        .o_keyboard_data(data1), .o_press_pulse(press1), .o_release_pulse(rel1),
        .o_repeat_pulse(rep1), .o_held_count(cnt1), .o_overflow(ovf1)
    );

    logic [7:0]  act_codes [16] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h24, 8'h5A, 8'h29, 8'h6B,
                                    8'h73, 8'h74, 8'h75, 8'h5B, 8'h5D, 8'h15, 8'h2D, 8'h76};
    logic [7:0]  pool [20] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h24, 8'h5A, 8'h29, 8'h6B, 8'h73, 8'h76,
                               8'h15, 8'h2D, 8'h5B, 8'h11, 8'h12, 8'h44, 8'h00, 8'h1D, 8'h29, 8'h1C};

    logic [7:0]  q[$];
    logic [15:0] p_press, p_rel;
    logic        p_ovf;
    int          age;

    function automatic logic [15:0] act(input logic [7:0] c);
        for (int i = 0; i < 16; i++)
            if (act_codes[i] == c) return 16'h0001 << i;
        return 16'h0000;
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic rn, input logic kv, input logic [15:0] kc, input logic cl);
        logic [15:0] e_d0, e_d1, e_pr, e_rl, e_rp;
        logic [3:0]  e_cnt;
        logic        e_ov, had;
        logic [7:0]  front, c;
        int          idx;
        @(negedge clk);
        rst_n = rn; key_valid = kv; keycode = kc; clear = cl;
        @(posedge clk);
        e_d0 = 0; e_d1 = 0; e_pr = 0; e_rl = 0; e_rp = 0; e_cnt = 0; e_ov = 0;
        if (!rn) begin
            q.delete();
            p_press = 0; p_rel = 0; p_ovf = 0; age = 0;
        end else begin
            e_d0  = q.size() > 0 ? act(q[0]) : 16'h0;
            foreach (q[i]) e_d1 |= act(q[i]);
            e_cnt = 4'(q.size());
            e_pr = p_press; e_rl = p_rel; e_ov = p_ovf;
            p_press = 0; p_rel = 0; p_ovf = 0;
            had   = q.size() > 0;
            front = had ? q[0] : 8'h00;
            c     = kc[7:0];
            idx   = -1;
            foreach (q[i]) if (q[i] == c) idx = i;
            if (cl) q.delete();
            else if (kv && c != 8'h00) begin
                if (kc[15:8] != 8'hF0) begin
                    if (idx < 0) begin
                        q.push_front(c);
                        p_press = act(c);
                        if (q.size() > MAXH) begin
                            p_rel = act(q.pop_back());
                            p_ovf = 1'b1;
                        end
                    end
                end else if (idx >= 0) begin
                    q.delete(idx);
                    p_rel = act(c);
                end
            end
            if (had && q.size() > 0 && q[0] == front) begin
                age++;
                if (age == DELAY || (age > DELAY && (age - DELAY) % RATE == 0)) e_rp = act(q[0]);
            end else age = 0;
        end
        #1;
        check("m0.data", data0, e_d0);    check("m1.data", data1, e_d1);
        check("m0.press", press0, e_pr);  check("m1.press", press1, e_pr);
        check("m0.release", rel0, e_rl);  check("m1.release", rel1, e_rl);
        check("m0.repeat", rep0, e_rp);   check("m1.repeat", rep1, e_rp);
        check("m0.count", {12'h0, cnt0}, {12'h0, e_cnt});
        check("m1.count", {12'h0, cnt1}, {12'h0, e_cnt});
        check("m0.overflow", {15'h0, ovf0}, {15'h0, e_ov});
        check("m1.overflow", {15'h0, ovf1}, {15'h0, e_ov});
    endtask

    task automatic press(input logic [7:0] c);   step(1'b1, 1'b1, {8'h00, c}, 1'b0); endtask
    task automatic release_(input logic [7:0] c); step(1'b1, 1'b1, {8'hF0, c}, 1'b0); endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0000, 1'b0);
    endtask

    initial begin
        p_press = 0; p_rel = 0; p_ovf = 0; age = 0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0000, 1'b0);
        press(8'h1D); idle(3);
        press(8'h1C); idle(2); release_(8'h1C); idle(3); release_(8'h1D); idle(2);
        press(8'h1D); press(8'h1C); press(8'h23); idle(2); release_(8'h1C); idle(3);
        step(1'b1, 1'b0, 16'h0000, 1'b1); idle(2);
        press(8'h1D); press(8'h1C); press(8'h1B); press(8'h23); press(8'h24); idle(3);
        step(1'b1, 1'b0, 16'h0000, 1'b1); idle(2);
        press(8'h29); idle(11); press(8'h1D); idle(20); release_(8'h1D); idle(12);
        release_(8'h5A); press(8'h1D); press(8'h1D); idle(2);
        step(1'b1, 1'b1, 16'h001C, 1'b1); idle(3);
        press(8'h76); press(8'h15); idle(2);
        step(1'b0, 1'b0, 16'h0000, 1'b0); idle(3);
        for (int n = 0; n < 4000; n++) begin
            int r;
            logic [7:0] c;
            r = $urandom_range(0, 99);
            c = pool[$urandom_range(0, 19)];
            if (r < 1)       step(1'b0, 1'($urandom_range(0, 1)), {8'h00, c}, 1'b0);
            else if (r < 4)  step(1'b1, 1'($urandom_range(0, 1)), {8'h00, c}, 1'b1);
            else if (r < 22) step(1'b1, 1'b1, {8'hF0, c}, 1'b0);
            else if (r < 45) step(1'b1, 1'b1, {($urandom_range(0, 1) != 0) ? 8'hE0 : 8'h00, c}, 1'b0);
            else             step(1'b1, 1'($urandom_range(0, 9) == 0) & 1'b0, {8'hF0, c}, 1'b0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/keyboard_tracker.md
Name: keyboard_tracker

Overview:
Parametrised successor to the two-key keyboard controller. It tracks up to MAX_HELD simultaneously held PS/2 keys in a press-ordered table and maps them onto a 16-bit one-hot/bitmask action bus. It also produces per-action press/release/repeat pulses and a held-key count. It sits after the keycode-change filter (consumes keycodev/start) and feeds game/UI logic.

Parameters:
MAX_HELD, 4, number of held-key slots (2..8).
MODE, 0, 0 = keyboard_data shows most-recent held mapped key only (legacy); 1 = OR of all held mapped keys.
REPEAT_DELAY, 50_000_000, cycles the newest key must stay newest before the first repeat pulse.
REPEAT_RATE, 5_000_000, cycles between subsequent repeat pulses.

Ports:
clk  in  1  system clock.
rst_n  in  1  synchronous active-low reset.
keycode_in  in  16  {prefix, code}; prefix F0 = release, anything else = press.
key_valid  in  1  one-cycle strobe qualifying keycode_in.
clear  in  1  synchronous flush of held table (no release pulses).
keyboard_data  out  16  action level bus (see MODE).
press_pulse  out  16  one-cycle pulse on mapped action when its key enters table.
release_pulse  out  16  one-cycle pulse on mapped action when its key leaves table.
repeat_pulse  out  16  one-cycle typematic pulse on newest key's action.
held_count  out  4  occupied slots.
overflow  out  1  one-cycle pulse when a press evicts the oldest slot.

Behaviour:
- Action map on code byte: 1D→0 (W), 1C→1 (A), 1B→2 (S), 23→3 (D), 24→4 (E), 5A→5 (Enter), 29→6 (Space), 6B→7, 73→8, 74→9, 75→10, 5B→11, 5D→12, 15→13 (Q), 2D→14 (R), 76→15 (Esc). Other codes are held/counted but map to no bit.
- Key identity = keycode_in[7:0]; code 00 ignored entirely.
- Table: slots 0..MAX_HELD-1, slot 0 newest; valid bits contiguous from slot 0.
- Press (key_valid, prefix != F0): code already held → no change, no pulse. Not held, not full → shift entries down one, insert at slot 0. Full → drop slot MAX_HELD-1 (its release_pulse fires), shift, insert; overflow pulses.
- Release (prefix F0): matching slot removed, younger entries unchanged, older entries shift up to close gap. No match → ignored.
- Table update on edge where key_valid sampled (edge N). All outputs registered from table/event, valid after edge N+1 (latency 2 edges from strobe to output).
- keyboard_data: MODE 0 = map(slot 0) if valid, else 0; MODE 1 = OR of map(all valid slots).
- Repeat counter: reloads when slot-0 identity changes or table empty; counts while slot 0 valid; pulse at REPEAT_DELAY, then every REPEAT_RATE; unmapped key → pulse bus stays 0.
- clear: empties table, held_count 0, counter reloaded, no pulses; clear has priority over key_valid in same cycle.
- Reset (rst_n=0 at edge): table empty, all outputs 0, counter reloaded; reset mid-hold drops keys silently.
- Pulses never span more than one cycle; press and release of different actions in the same cycle cannot occur except eviction (release of evicted + press of new, same cycle).

Test Plan:
- Reset, press 1D → keyboard_data=0x0001 and press_pulse=0x0001 two edges after strobe; held_count=1.
- MODE 0: press 1D, press 1C, release 1C → data 0x0001→0x0002→0x0001; release_pulse=0x0002 once.
- MODE 1: press 1D,1C,23 → data=0x000B; release 1C (middle) → data=0x0009, held_count=2, slot order 23,1D.
- MAX_HELD=4: press 1D,1C,1B,23,24 → overflow pulse, release_pulse=0x0001, data(MODE1)=0x001E, held_count=4.
- REPEAT_DELAY=10, REPEAT_RATE=4: hold 29 → repeat_pulse=0x0040 at 10, 14, 18 cycles after entry; press 1D at cycle 12 → repeats restart for bit 0.
- Release of unheld key F0_5A, duplicate press 1D, clear with simultaneous key_valid, rst_n low mid-hold → no pulses, table empty/unchanged as specified.
